fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 140 ++++++++++++++
 tb/tb_fetch_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues one instruction-memory request at a time,
// delivers responses into the IF/ID register, and parks one response in a skid
// buffer when decode is stalled. A taken branch redirects the PC. A request
// that is still in flight when the branch arrives is drained, and its data is
// dropped.
//
// Memory handshake: imem_req is high in FETCH and DRAIN and low in HOLD.
// imem_addr (req_addr) stays constant while imem_req is high and no ack has
// arrived. An imem_ack strobe completes the current request. It is only
// honoured while imem_req is high, and imem_rdata is valid in the same cycle.
module fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_d,
    input  logic        br_taken,
    input  logic [63:0] br_target,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_d,
    output logic [63:0] pc_d,
    output logic        valid_d,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [63:0] pc, pc_n;
    logic [63:0] req_addr, req_addr_n;
    logic [31:0] skid_instr, skid_instr_n;
    logic [63:0] skid_pc, skid_pc_n;
    logic [31:0] instr_n;
    logic [63:0] pc_d_n;
    logic        valid_n;
    logic [63:0] pc_inc;
    logic        ack;
    logic        if_id_free;

    assign imem_req   = (state != HOLD);
    assign imem_addr  = req_addr;
    assign fsm_state  = state;
    assign pc_inc     = pc + 64'd4;   // wraps modulo 2^64
    assign ack        = imem_ack && imem_req;
    assign if_id_free = !valid_d || !stall_d;

    // Next-state, PC, skid buffer and IF/ID computation; branch overrides everything but reset.
    always_comb begin
        state_n      = state;
        pc_n         = pc;
        req_addr_n   = req_addr;
        skid_instr_n = skid_instr;
        skid_pc_n    = skid_pc;
        instr_n      = instr_d;
        pc_d_n       = pc_d;
        valid_n      = valid_d;

        if (br_taken) begin
            pc_n         = {br_target[63:2], 2'b00};
            valid_n      = 1'b0;
            skid_instr_n = 32'h0;
            skid_pc_n    = 64'h0;
            case (state)
                FETCH:   state_n = ack ? FETCH : DRAIN;
                HOLD:    state_n = FETCH;
                DRAIN:   state_n = DRAIN;
                default: state_n = FETCH;
            endcase
        end else begin
            case (state)
                FETCH: begin
                    if (ack) begin
                        pc_n = pc_inc;
                        if (if_id_free) begin
                            instr_n = imem_rdata;
                            pc_d_n  = req_addr;
                            valid_n = 1'b1;
                        end else begin
                            skid_instr_n = imem_rdata;
                            skid_pc_n    = req_addr;
                            state_n      = HOLD;
                        end
                    end else if (valid_d && !stall_d) begin
                        valid_n = 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall_d) begin
                        instr_n = skid_instr;
                        pc_d_n  = skid_pc;
                        valid_n = 1'b1;
                        state_n = FETCH;
                    end
                end
                DRAIN: begin
                    // Stale response is dropped; the next FETCH cycle requests the new PC.
                    if (ack) state_n = FETCH;
                    if (valid_d && !stall_d) valid_n = 1'b0;
                end
                default: state_n = FETCH;
            endcase
        end

        // A new request starts on entry to FETCH or on any ack that stays in FETCH.
        if (state_n == FETCH && (state != FETCH || ack)) begin
            req_addr_n = pc_n;
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            req_addr   <= RESET_PC;
            skid_instr <= 32'h0;
            skid_pc    <= 64'h0;
            instr_d    <= 32'h0;
            pc_d       <= 64'h0;
            valid_d    <= 1'b0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            req_addr   <= req_addr_n;
            skid_instr <= skid_instr_n;
            skid_pc    <= skid_pc_n;
            instr_d    <= instr_n;
            pc_d       <= pc_d_n;
            valid_d    <= valid_n;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: zero-wait streaming, decode stall with skid,
// branch flush while a request is in flight, branch under stall, PC wrap, and
// asynchronous reset in the middle of a drain.
module tb_fetch_unit;

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_HOLD  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic        clk;
    logic        reset;
    logic        stall_d;
    logic        br_taken;
    logic [63:0] br_target;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr_d;
    logic [63:0] pc_d;
    logic        valid_d;
    logic [1:0]  fsm_state;

    int n_tests;
    int n_fail;

    fetch_unit #(.RESET_PC(64'h0)) dut (
        .clk       (clk),
        .reset     (reset),
        .stall_d   (stall_d),
        .br_taken  (br_taken),
        .br_target (br_target),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_rdata(imem_rdata),
        .instr_d   (instr_d),
        .pc_d      (pc_d),
        .valid_d   (valid_d),
        .fsm_state (fsm_state)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction word the memory returns for a given address.
    function automatic logic [31:0] instr_of(input logic [63:0] addr);
        return 32'hC0DE_0000 | {16'h0, addr[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, then return at the next falling edge.
    task automatic cyc(input logic ack, input logic stall, input logic br, input logic [63:0] tgt);
        imem_ack   = ack;
        stall_d    = stall;
        br_taken   = br;
        br_target  = tgt;
        imem_rdata = ack ? instr_of(imem_addr) : 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        imem_ack   = 1'b0;
        stall_d    = 1'b0;
        br_taken   = 1'b0;
        br_target  = 64'h0;
        imem_rdata = 32'h0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;

        // Reset values and first request
        do_reset();
        chk("rst_valid", 64'(valid_d), 64'h0);
        chk("rst_instr", 64'(instr_d), 64'h0);
        chk("rst_pc_d", pc_d, 64'h0);
        chk("rst_req", 64'(imem_req), 64'h1);
        chk("rst_addr", imem_addr, 64'h0);
        chk("rst_state", 64'(fsm_state), 64'(S_FETCH));

        // Zero-wait streaming: pc_d 0,4,8,C on consecutive cycles
        cyc(1, 0, 0, 0);
        chk("zw_valid0", 64'(valid_d), 64'h1);
        chk("zw_pc0", pc_d, 64'h0);
        chk("zw_instr0", 64'(instr_d), 64'(instr_of(64'h0)));
        cyc(1, 0, 0, 0);
        chk("zw_pc4", pc_d, 64'h4);
        cyc(1, 0, 0, 0);
        chk("zw_pc8", pc_d, 64'h8);
        cyc(1, 0, 0, 0);
        chk("zw_pcC", pc_d, 64'hC);
        chk("zw_instrC", 64'(instr_d), 64'(instr_of(64'hC)));
        chk("zw_addr10", imem_addr, 64'h10);

        // Stall while ack for 0x8 arrives -> HOLD with skid
        do_reset();
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("st_pc4", pc_d, 64'h4);
        chk("st_addr8", imem_addr, 64'h8);
        cyc(1, 1, 0, 0);
        chk("st_hold", 64'(fsm_state), 64'(S_HOLD));
        chk("st_req0", 64'(imem_req), 64'h0);
        chk("st_pc_hold1", pc_d, 64'h4);
        chk("st_valid_hold", 64'(valid_d), 64'h1);
        cyc(0, 1, 0, 0);
        chk("st_pc_hold2", pc_d, 64'h4);
        cyc(0, 1, 0, 0);
        chk("st_pc_hold3", pc_d, 64'h4);
        chk("st_hold3", 64'(fsm_state), 64'(S_HOLD));
        cyc(0, 0, 0, 0);
        chk("st_pc8", pc_d, 64'h8);
        chk("st_instr8", 64'(instr_d), 64'(instr_of(64'h8)));
        chk("st_valid8", 64'(valid_d), 64'h1);
        chk("st_fetch", 64'(fsm_state), 64'(S_FETCH));
        chk("st_addrC", imem_addr, 64'hC);
        cyc(1, 0, 0, 0);
        chk("st_pcC", pc_d, 64'hC);
        chk("st_addr10", imem_addr, 64'h10);

        // Branch to 0x100 while request for 0x10 is pending -> DRAIN
        cyc(0, 0, 1, 64'h100);
        chk("dr_state", 64'(fsm_state), 64'(S_DRAIN));
        chk("dr_valid", 64'(valid_d), 64'h0);
        chk("dr_addr1", imem_addr, 64'h10);
        chk("dr_req", 64'(imem_req), 64'h1);
        cyc(0, 0, 0, 0);
        chk("dr_addr2", imem_addr, 64'h10);
        cyc(1, 0, 0, 0);
        chk("dr_valid_after", 64'(valid_d), 64'h0);
        chk("dr_back_fetch", 64'(fsm_state), 64'(S_FETCH));
        chk("dr_addr100", imem_addr, 64'h100);
        cyc(1, 0, 0, 0);
        chk("dr_pc100", pc_d, 64'h100);
        chk("dr_instr100", 64'(instr_d), 64'(instr_of(64'h100)));
        chk("dr_addr104", imem_addr, 64'h104);

        // Branch under stall with valid_d=1; target 0x203 fetched as 0x200
        cyc(0, 1, 1, 64'h203);
        chk("bs_valid0", 64'(valid_d), 64'h0);
        chk("bs_drain", 64'(fsm_state), 64'(S_DRAIN));
        cyc(1, 0, 0, 0);
        chk("bs_addr200", imem_addr, 64'h200);
        cyc(1, 0, 0, 0);
        chk("bs_pc200", pc_d, 64'h200);
        chk("bs_valid1", 64'(valid_d), 64'h1);

        // Branch with simultaneous ack: response discarded, fetch top of memory, wrap to 0
        cyc(1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wr_valid0", 64'(valid_d), 64'h0);
        chk("wr_state", 64'(fsm_state), 64'(S_FETCH));
        chk("wr_addr_top", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        cyc(1, 0, 0, 0);
        chk("wr_pc_top", pc_d, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wr_addr0", imem_addr, 64'h0);
        cyc(1, 0, 0, 0);
        chk("wr_pc0", pc_d, 64'h0);
        cyc(1, 0, 0, 0);
        chk("wr_pc4", pc_d, 64'h4);

        // Asynchronous reset mid-DRAIN
        cyc(0, 1, 1, 64'h40);
        chk("ar_drain", 64'(fsm_state), 64'(S_DRAIN));
        chk("ar_pc_d_pre", pc_d, 64'h4);
        #2 reset = 1'b1;
        #1;
        chk("ar_pc_d", pc_d, 64'h0);
        chk("ar_instr", 64'(instr_d), 64'h0);
        chk("ar_valid", 64'(valid_d), 64'h0);
        chk("ar_state", 64'(fsm_state), 64'(S_FETCH));
        chk("ar_addr", imem_addr, 64'h0);
        @(negedge clk);
        reset    = 1'b0;
        br_taken = 1'b0;
        stall_d  = 1'b0;
        chk("ar_req_rel", 64'(imem_req), 64'h1);
        chk("ar_addr_rel", imem_addr, 64'h0);
        cyc(1, 0, 0, 0);
        chk("ar_pc0", pc_d, 64'h0);
        chk("ar_valid1", 64'(valid_d), 64'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
